branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, the address/data width.
REQ-002 SHALL have parameter IDX_W, default 4, the table index width (2^IDX_W entries).
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_pc  input  XLEN  fetch-stage PC.
REQ-006 SHALL have port pred_taken  output  1  fetch predicts taken.
REQ-007 SHALL have port pred_target  output  XLEN  predicted target, valid when pred_taken=1.
REQ-008 SHALL have port ex_valid  input  1  resolved instruction present in EX.
REQ-009 SHALL have port ex_branch  input  1  EX instruction is a conditional branch (opcode 5'b11000).
REQ-010 SHALL have port ex_pc  input  XLEN  PC of the EX instruction.
REQ-011 SHALL have port ex_pred_taken  input  1  prediction carried down the pipe with that instruction.
REQ-012 SHALL have port ex_decision  input  1  actual outcome from the branch-condition unit.
REQ-013 SHALL have port ex_target  input  XLEN  computed branch target.
REQ-014 SHALL have port flush  output  1  squash IF/ID and redirect, registered.
REQ-015 SHALL have port redirect_pc  output  XLEN  fetch PC to use when flush=1, registered.
REQ-016 SHALL have ports br_count and mp_count  output  16 each  resolved-branch and mispredict counters.

Function
REQ-017 SHALL index both tables with idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
REQ-018 SHALL hold per entry one 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-019 SHALL hold per entry a BTB slot with a valid bit, a tag, and an XLEN-bit target.
REQ-020 SHALL compute the lookup combinationally from if_pc: pred_taken = BTB valid & tag match & counter[1]; pred_target = BTB target.
REQ-021 SHALL form a resolve event when ex_valid & ex_branch & !flush.
REQ-022 SHALL, on a resolve event, update the counter at ex_pc's idx on the clock edge: taken increments saturating at 11; not-taken decrements saturating at 00.
REQ-023 SHALL, on a resolve event with ex_decision=1, write the BTB entry: valid=1, tag from ex_pc, target=ex_target.
REQ-024 SHALL leave the BTB unchanged on a resolve event with ex_decision=0.
REQ-025 SHALL detect a mispredict on a resolve event when ex_pred_taken != ex_decision.
REQ-026 SHALL also detect a mispredict when ex_pred_taken=1 and ex_decision=1 but the BTB target read at ex_pc != ex_target.
REQ-027 SHALL, on a mispredict, set flush=1 for exactly the next cycle (latency 1).
REQ-028 SHALL set redirect_pc = ex_target if ex_decision=1, else ex_pc+4, with wrap modulo 2^XLEN.
REQ-029 SHALL otherwise drive flush=0 and hold redirect_pc at its last value.
REQ-030 SHALL ignore EX inputs (no update, no count, no new flush) in any cycle where flush=1, because that instruction is wrong-path.
REQ-031 SHALL give no bypass when lookup and update hit the same idx in one cycle: the lookup returns the pre-update value.
REQ-032 SHALL increment br_count on each resolve event and mp_count on each mispredict, both saturating at 16'hFFFF.
REQ-033 SHALL do nothing when ex_valid=1 and ex_branch=0.

Reset
REQ-034 SHALL, while rst=1, immediately set all counters to 01 (WNT), all BTB valid bits to 0, flush=0, redirect_pc=0, br_count=0, mp_count=0.
REQ-035 SHALL, on reset asserted mid-operation, drop a pending flush the same instant; the first resolve event may occur on the first rising edge after rst falls.

Verification
REQ-036 Bench SHALL check: after reset, if_pc=0x100 -> pred_taken=0; br_count=0; mp_count=0.
REQ-037 Bench SHALL check: resolve ex_pc=0x100, pred 0, decision 1, target 0x200 -> next cycle flush=1, redirect_pc=0x200, mp_count=1; then if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-038 Bench SHALL check: resolve ex_pc=0x104, pred 1, decision 0 -> next cycle flush=1, redirect_pc=0x108; a resolve event presented during that flush cycle -> no counter or BTB change.
REQ-039 Bench SHALL check: 4 taken resolves at 0x100 then 1 not-taken -> counter 11 then 10; pred_taken stays 1.
REQ-040 Bench SHALL check: alias 0x100 vs 0x140 with IDX_W=4 -> tag mismatch, pred_taken=0; same-cycle lookup and update of one idx -> old value returned.
REQ-041 Bench SHALL check: rst pulsed while flush=1 -> flush=0 immediately; mp_count forced to 16'hFFFF, one more mispredict -> holds 16'hFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// Purpose: direct-mapped 2-bit counter + BTB predictor with EX-stage resolve and registered flush/redirect.
// Latency: lookup is combinational from if_pc; flush/redirect_pc follow a mispredict by one cycle.
// Backpressure: none; EX inputs are ignored while flush=1 (wrong-path instruction).
module branch_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_decision,
  input  logic [XLEN-1:0] ex_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  logic [1:0]       r_cnt     [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [XLEN-1:0]  r_btb_tgt [ENTRIES];
  logic [ENTRIES-1:0] r_btb_vld;
  logic             r_flush;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [15:0]      r_br_count;
  logic [15:0]      r_mp_count;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_resolve;
  logic             w_tgt_miss;
  logic             w_mispredict;
  logic [1:0]       w_cnt_cur;
  logic [1:0]       w_cnt_next;
  logic [XLEN-1:0]  w_redirect;
  logic             w_unused_if_lsb;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
  // Instructions are word aligned, so the low PC bits never select an entry.
  assign w_unused_if_lsb = ^if_pc[1:0];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign pred_taken  = r_btb_vld[w_if_idx] & (r_btb_tag[w_if_idx] == w_if_tag) & r_cnt[w_if_idx][1];
  assign pred_target = r_btb_tgt[w_if_idx];

  // A pending flush marks the EX instruction as wrong-path, so it cannot resolve.
  assign w_resolve    = ex_valid & ex_branch & ~r_flush;
  // A correct taken guess with a stale target still sends fetch to the wrong place.
  assign w_tgt_miss   = ex_pred_taken & ex_decision & (r_btb_tgt[w_ex_idx] != ex_target);
  assign w_mispredict = w_resolve & ((ex_pred_taken != ex_decision) | w_tgt_miss);
  assign w_redirect   = ex_decision ? ex_target : (ex_pc + XLEN'(4));

  // Saturating 2-bit counter step toward the resolved outcome.
  always_comb begin
    w_cnt_cur  = r_cnt[w_ex_idx];
    w_cnt_next = w_cnt_cur;
    if (ex_decision) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
    end
  end

  // Prediction tables: counters train on every resolve, BTB only learns taken branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btb_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i]     <= 2'b01;
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (w_resolve) begin
      r_cnt[w_ex_idx] <= w_cnt_next;
      if (ex_decision) begin
        r_btb_vld[w_ex_idx] <= 1'b1;
        r_btb_tag[w_ex_idx] <= w_ex_tag;
        r_btb_tgt[w_ex_idx] <= ex_target;
      end
    end
  end

  // One-cycle flush pulse; redirect PC holds its last value between mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_redirect;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else begin
      if (w_resolve && (r_br_count != 16'hFFFF))    r_br_count <= r_br_count + 16'd1;
      if (w_mispredict && (r_mp_count != 16'hFFFF)) r_mp_count <= r_mp_count + 16'd1;
    end
  end

  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign br_count    = r_br_count;
  assign mp_count    = r_mp_count;

endmodule
